// File: rtl/mfp_heartbeat_sampler_if.sv
// Software read port of the heartbeat sampler: head-of-FIFO word, ready flag and level ACK.
interface mfp_heartbeat_sampler_if;
    logic [31:0] IO_HEARTBEAT;
    logic        IO_READ_RDY;
    logic        IO_READ_ACK;

    modport master (output IO_HEARTBEAT, output IO_READ_RDY, input IO_READ_ACK);
    modport slave  (input IO_HEARTBEAT, input IO_READ_RDY, output IO_READ_ACK);
endinterface

// File: rtl/mfp_heartbeat_sampler.sv
// Pulse-sensor heartbeat sampler: debounced beat interval words queued for software readout.
// Optional BPM divider enabled by defining MFP_HEARTBEAT_BPM_EN.
module mfp_heartbeat_sampler #(
    parameter int unsigned CLK_FREQ_HZ   = 50000000,
    parameter int unsigned FIFO_AW       = 3,
    parameter int unsigned REFRACTORY_MS = 250,
    parameter int unsigned TIMEOUT_MS    = 3000
) (
    input  logic                           HCLK,
    input  logic                           HRESET,
    input  logic                           BEAT_IN,
    mfp_heartbeat_sampler_if.master        io,
    output logic [7:0]                     HB_BPM,
    output logic                           HB_OVERFLOW
);
    localparam int unsigned TICK_CYCLES = CLK_FREQ_HZ / 1000;
    localparam int unsigned PRESC_W     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);
    localparam int unsigned DEPTH       = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [15:0] REFR_LOAD    = 16'(REFRACTORY_MS);
    localparam logic [15:0] TIMEOUT_WORD = 16'(TIMEOUT_MS);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_MS - 1);

    function automatic logic [31:0] pack_word(input logic [7:0]  seq,
                                              input logic        tmo,
                                              input logic        ovf,
                                              input logic        first,
                                              input logic [15:0] interval);
        pack_word = {seq, tmo, ovf, first, 5'b00000, interval};
    endfunction

    logic                 sync1_q, sync2_q, sync_prev_q;
    logic                 beat_edge_q, beat_edge_d;
    logic                 ack_q;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [15:0]          ms_cnt_q, ms_cnt_d;
    logic [15:0]          refr_q, refr_d;
    logic [7:0]           seq_q, seq_d;
    logic                 first_q, first_d;
    logic                 armed_q, armed_d;
    logic                 ovf_q, ovf_d;
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     count_q, count_d;
    logic                 rdy_q, rdy_d;
    logic [31:0]          head_q, head_d;
    logic [31:0]          mem_q [DEPTH];

    logic                 tick_s, accept_s, timeout_s, push_s, pop_s, push_ok_s, ack_rise_s;
    logic [31:0]          push_word_s;

    // Next state: timebase, beat acceptance, timeout, word packing and FIFO bookkeeping.
    always_comb begin
        tick_s      = (presc_q == PRESC_LAST);
        beat_edge_d = sync2_q && !sync_prev_q;
        accept_s    = beat_edge_q && (refr_q == 16'd0);
        timeout_s   = armed_q && tick_s && (ms_cnt_q == TIMEOUT_LAST) && !accept_s;
        push_s      = accept_s || timeout_s;
        ack_rise_s  = io.IO_READ_ACK && !ack_q;
        pop_s       = ack_rise_s && (count_q != {(FIFO_AW+1){1'b0}});
        push_ok_s   = push_s && ((count_q != DEPTH_C) || pop_s);
        push_word_s = pack_word(seq_q, timeout_s, ovf_q, first_q,
                                accept_s ? ms_cnt_q : TIMEOUT_WORD);

        if (tick_s) presc_d = {PRESC_W{1'b0}};
        else        presc_d = presc_q + 1'b1;

        if (accept_s)                             ms_cnt_d = 16'd0;
        else if (tick_s && (ms_cnt_q != 16'hFFFF)) ms_cnt_d = ms_cnt_q + 16'd1;
        else                                      ms_cnt_d = ms_cnt_q;

        if (accept_s)                            refr_d = REFR_LOAD;
        else if (tick_s && (refr_q != 16'd0))    refr_d = refr_q - 16'd1;
        else                                     refr_d = refr_q;

        if (accept_s) begin
            seq_d   = seq_q + 8'd1;
            first_d = 1'b0;
            armed_d = 1'b1;
        end else begin
            seq_d   = seq_q;
            first_d = first_q;
            armed_d = timeout_s ? 1'b0 : armed_q;
        end

        // The flag rides on the next word that actually lands, then clears.
        if (push_ok_s)   ovf_d = 1'b0;
        else if (push_s) ovf_d = 1'b1;
        else             ovf_d = ovf_q;

        if (push_ok_s) wr_ptr_d = wr_ptr_q + 1'b1;
        else           wr_ptr_d = wr_ptr_q;
        if (pop_s)     rd_ptr_d = rd_ptr_q + 1'b1;
        else           rd_ptr_d = rd_ptr_q;

        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        rdy_d = (count_d != {(FIFO_AW+1){1'b0}});
        if (!rdy_d)                                       head_d = 32'h0000_0000;
        else if (push_ok_s && (wr_ptr_q == rd_ptr_d))     head_d = push_word_s;
        else                                              head_d = mem_q[rd_ptr_d];
    end

    // Control and status registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync_prev_q <= 1'b0;
            beat_edge_q <= 1'b0;
            ack_q       <= 1'b0;
            presc_q     <= {PRESC_W{1'b0}};
            ms_cnt_q    <= 16'd0;
            refr_q      <= 16'd0;
            seq_q       <= 8'd0;
            first_q     <= 1'b1;
            armed_q     <= 1'b1;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= {FIFO_AW{1'b0}};
            rd_ptr_q    <= {FIFO_AW{1'b0}};
            count_q     <= {(FIFO_AW+1){1'b0}};
            rdy_q       <= 1'b0;
            head_q      <= 32'h0000_0000;
        end else begin
            sync1_q     <= BEAT_IN;
            sync2_q     <= sync1_q;
            sync_prev_q <= sync2_q;
            beat_edge_q <= beat_edge_d;
            ack_q       <= io.IO_READ_ACK;
            presc_q     <= presc_d;
            ms_cnt_q    <= ms_cnt_d;
            refr_q      <= refr_d;
            seq_q       <= seq_d;
            first_q     <= first_d;
            armed_q     <= armed_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rdy_q       <= rdy_d;
            head_q      <= head_d;
        end
    end

    // FIFO storage, cleared on reset so discarded words never resurface.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            mem_q <= '{default: 32'h0000_0000};
        end else if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_word_s;
        end
    end

    assign io.IO_HEARTBEAT = head_q;
    assign io.IO_READ_RDY  = rdy_q;
    assign HB_OVERFLOW     = ovf_q;

`ifdef MFP_HEARTBEAT_BPM_EN
    logic        div_busy_q, div_busy_d;
    logic [4:0]  div_cnt_q, div_cnt_d;
    logic [15:0] div_quo_q, div_quo_d, div_dvs_q, div_dvs_d;
    logic [16:0] div_rem_q, div_rem_d, rem_sh_s;
    logic [7:0]  bpm_q, bpm_d;
    logic        div_start_s;

    // Restoring divider 60000/interval: 16 shift-subtract steps, then saturating write.
    always_comb begin
        div_start_s = accept_s && !first_q && (ms_cnt_q != 16'd0);
        rem_sh_s    = {div_rem_q[15:0], div_quo_q[15]};
        div_busy_d  = div_busy_q;
        div_cnt_d   = div_cnt_q;
        div_quo_d   = div_quo_q;
        div_dvs_d   = div_dvs_q;
        div_rem_d   = div_rem_q;
        bpm_d       = bpm_q;
        if (div_start_s) begin
            div_busy_d = 1'b1;
            div_cnt_d  = 5'd0;
            div_quo_d  = 16'd60000;
            div_dvs_d  = ms_cnt_q;
            div_rem_d  = 17'd0;
        end else if (timeout_s) begin
            div_busy_d = 1'b0;
            bpm_d      = 8'd0;
        end else if (div_busy_q) begin
            if (div_cnt_q == 5'd16) begin
                div_busy_d = 1'b0;
                bpm_d      = (div_quo_q > 16'd255) ? 8'hFF : div_quo_q[7:0];
            end else begin
                div_cnt_d = div_cnt_q + 5'd1;
                if (rem_sh_s >= {1'b0, div_dvs_q}) begin
                    div_rem_d = rem_sh_s - {1'b0, div_dvs_q};
                    div_quo_d = {div_quo_q[14:0], 1'b1};
                end else begin
                    div_rem_d = rem_sh_s;
                    div_quo_d = {div_quo_q[14:0], 1'b0};
                end
            end
        end else begin
            div_busy_d = 1'b0;
        end
    end

    // Divider and BPM registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            div_busy_q <= 1'b0;
            div_cnt_q  <= 5'd0;
            div_quo_q  <= 16'd0;
            div_dvs_q  <= 16'd0;
            div_rem_q  <= 17'd0;
            bpm_q      <= 8'd0;
        end else begin
            div_busy_q <= div_busy_d;
            div_cnt_q  <= div_cnt_d;
            div_quo_q  <= div_quo_d;
            div_dvs_q  <= div_dvs_d;
            div_rem_q  <= div_rem_d;
            bpm_q      <= bpm_d;
        end
    end

    assign HB_BPM = bpm_q;
`else
    assign HB_BPM = 8'h00;
`endif

endmodule
